trace_monitor: RTL and testbench
================================

TRACE_MONITOR -- requirements
Module: trace_monitor

Interface
REQ-001 Parameter DEPTH, default 16, number of PC history entries (power of two, 2..256).
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, cycles after reset before timeout is declared.
REQ-003 Port sysClk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port sysRes  input  1  reset, asynchronous, active-high.
REQ-005 Port pc  input  32  current CPU program counter.
REQ-006 Port instrData  input  32  instruction-bus data for the fetched word.
REQ-007 Port instrValid  input  1  pc/instrData qualify this cycle.
REQ-008 Port status  output  2  00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT.
REQ-009 Port done  output  1  high when status != RUN.
REQ-010 Port rdReq  input  1  request to pop one history entry.
REQ-011 Port rdData  output  32  popped PC value, valid while rdValid.
REQ-012 Port rdValid  output  1  one-cycle pulse qualifying rdData.
REQ-013 Port rdEmpty  output  1  no unread history entries remain.

Function
REQ-014 States RUN, PASS, FAIL, TIMEOUT; status encodes the state; done = (state != RUN).
REQ-015 In RUN, each cycle with instrValid=1 shall write pc into the circular buffer at wrPtr, advance wrPtr modulo DEPTH, and increment count saturating at DEPTH.
REQ-016 When count == DEPTH, a write shall overwrite the oldest entry; rdPtr shall advance with wrPtr so the buffer always holds the newest DEPTH values oldest-first.
REQ-017 In RUN with instrValid=1: instrData == 32'h00000001 -> PASS; instrData == 32'h00000000 -> FAIL; transition on the same edge that records that cycle's pc.
REQ-018 status/done shall reflect PASS/FAIL/TIMEOUT from the cycle after the detecting edge (one-cycle latency).
REQ-019 PASS, FAIL, TIMEOUT are terminal until reset; no further buffer writes occur.
REQ-020 rdReq shall be ignored in RUN; in any terminal state with rdEmpty=0, rdReq pops the oldest entry: rdData/rdValid are presented on the next cycle, rdPtr advances, count decrements.
REQ-021 rdReq with rdEmpty=1 shall produce no rdValid and leave pointers unchanged; rdData holds its last value.
REQ-022 Back-to-back rdReq shall yield one entry per cycle, oldest to newest, wrapping rdPtr modulo DEPTH.
REQ-023 rdEmpty = (count == 0).

Reset
REQ-024 sysRes high shall immediately force state RUN, status 00, done 0, wrPtr 0, rdPtr 0, count 0, rdValid 0, rdData 0, rdEmpty 1, timeout counter 0; buffer contents need not be cleared.
REQ-025 Reset asserted mid-readout or mid-run shall abandon the operation; no partial rdValid after reset release.

Configuration
REQ-026 Macro TRACE_MONITOR_TIMEOUT_EN defined: a cycle counter runs in RUN from reset release; when it reaches TIMEOUT_CYCLES-1 the state goes to TIMEOUT on that edge.
REQ-027 Same-edge PASS/FAIL detection and timeout: PASS/FAIL wins.
REQ-028 Macro undefined: no counter is instantiated; state TIMEOUT is unreachable; status never reads 11.

Verification
REQ-029 Reset, 5 valid fetches pc=0x00,0x04,0x08,0x0C,0x10 with instrData=0x13, then instrData=0x1 at pc=0x14 -> status=01, done=1 one cycle later; 6 pops return 0x00..0x14; then rdEmpty=1.
REQ-030 DEPTH=16, 20 fetches pc=0x00..0x4C step 4 ending instrData=0x0 at pc=0x4C -> status=10; 16 pops return 0x10..0x4C; 17th rdReq -> no rdValid.
REQ-031 rdReq held high during RUN for 10 cycles -> no rdValid, count unchanged, capture unaffected.
REQ-032 With TRACE_MONITOR_TIMEOUT_EN, TIMEOUT_CYCLES=100, no pass/fail word -> status=11 after edge 99; same run with instrData=0x1 on edge 99 -> status=01.
REQ-033 sysRes pulsed after 3 of 8 pops -> status=00, rdEmpty=1, rdValid=0 immediately, without waiting for a clock edge.
REQ-034 instrValid=0 with instrData=0x0 for 5 cycles -> status stays 00, count stays 0.

Source files
------------

// File: rtl/trace_monitor.sv
// Captures valid PC fetches in a circular history until a PASS/FAIL marker word (or optional timeout),
// then pops oldest-first on rdReq with one-cycle read latency. Timeout is built only with TRACE_MONITOR_TIMEOUT_EN.
module trace_monitor #(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        sysClk,
  input  logic        sysRes,
  input  logic [31:0] pc,
  input  logic [31:0] instrData,
  input  logic        instrValid,
  output logic [1:0]  status,
  output logic        done,
  input  logic        rdReq,
  output logic [31:0] rdData,
  output logic        rdValid,
  output logic        rdEmpty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_rd_data;
  logic          r_rd_valid;
  logic          w_run;
  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_pass_hit;
  logic          w_fail_hit;
  logic          w_to_hit;

  assign w_run      = (r_state == ST_RUN);
  assign w_wr_en    = w_run && instrValid;
  assign w_pass_hit = w_wr_en && (instrData == 32'h0000_0001);
  assign w_fail_hit = w_wr_en && (instrData == 32'h0000_0000);
  assign w_rd_en    = !w_run && rdReq && (r_count != '0);

`ifdef TRACE_MONITOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LP_TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_to_cnt;

  assign w_to_hit = w_run && (r_to_cnt == LP_TO_LAST);

  always_ff @(posedge sysClk or posedge sysRes) begin
    if (sysRes) begin
      r_to_cnt <= '0;
    end else if (w_run && !w_to_hit) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_to_hit         = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge sysClk or posedge sysRes) begin
    if (sysRes) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Marker word beats timeout when both land on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    if (w_run) begin
      if (w_pass_hit) begin
        w_state_nxt = ST_PASS;
      end else if (w_fail_hit) begin
        w_state_nxt = ST_FAIL;
      end else if (w_to_hit) begin
        w_state_nxt = ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge sysClk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= pc;
    end
  end

  // Writes only happen in RUN and reads only outside it, so the two paths never collide.
  always_ff @(posedge sysClk or posedge sysRes) begin
    if (sysRes) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_count == LP_FULL) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
      if (w_rd_en) begin
        r_rd_data  <= r_mem[r_rd_ptr];
        r_rd_valid <= 1'b1;
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_count    <= r_count - 1'b1;
      end
    end
  end

  assign status  = r_state;
  assign done    = !w_run;
  assign rdData  = r_rd_data;
  assign rdValid = r_rd_valid;
  assign rdEmpty = (r_count == '0);

endmodule

// File: tb/tb_trace_monitor.sv
// Directed bench for trace_monitor: capture, pass/fail, readout wrap, reset abort and timeout.
module tb_trace_monitor;

  logic        sysClk;
  logic        sysRes;
  logic [31:0] pc;
  logic [31:0] instrData;
  logic        instrValid;
  logic [1:0]  status;
  logic        done;
  logic        rdReq;
  logic [31:0] rdData;
  logic        rdValid;
  logic        rdEmpty;

  int n_checks = 0;
  int n_errors = 0;

  trace_monitor #(
    .DEPTH          (16),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .sysClk     (sysClk),
    .sysRes     (sysRes),
    .pc         (pc),
    .instrData  (instrData),
    .instrValid (instrValid),
    .status     (status),
    .done       (done),
    .rdReq      (rdReq),
    .rdData     (rdData),
    .rdValid    (rdValid),
    .rdEmpty    (rdEmpty)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge sysClk);
    #1;
    sysRes = 1'b1;
    #2;
    chk("rst_status", 32'(status), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_empty", 32'(rdEmpty), 32'h1);
    chk("rst_rdvalid", 32'(rdValid), 32'h0);
    chk("rst_rddata", rdData, 32'h0);
    #2;
    sysRes = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d);
    pc         = a;
    instrData  = d;
    instrValid = 1'b1;
    @(posedge sysClk);
    #1;
    instrValid = 1'b0;
    instrData  = 32'h13;
  endtask

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  initial begin
    sysRes     = 1'b0;
    pc         = 32'h0;
    instrData  = 32'h13;
    instrValid = 1'b0;
    rdReq      = 1'b0;

    do_reset();

    // Invalid fetches carrying a FAIL word must be ignored
    instrData = 32'h0;
    repeat (5) tick();
    chk("idle_status", 32'(status), 32'h0);
    chk("idle_empty", 32'(rdEmpty), 32'h1);
    instrData = 32'h13;

    // rdReq held through RUN: ignored, capture unaffected
    rdReq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fetch(32'(i * 4), 32'h13);
      chk("run_rd_ignored", 32'(rdValid), 32'h0);
    end
    repeat (4) begin
      tick();
      chk("run_rd_ignored_idle", 32'(rdValid), 32'h0);
    end
    chk("run_status", 32'(status), 32'h0);
    chk("run_not_empty", 32'(rdEmpty), 32'h0);
    fetch(32'h14, 32'h1);
    chk("pass_status", 32'(status), 32'h1);
    chk("pass_done", 32'(done), 32'h1);
    chk("pass_no_rdvalid", 32'(rdValid), 32'h0);
    rdReq = 1'b0;
    fetch(32'h99, 32'h0);
    chk("pass_terminal", 32'(status), 32'h1);

    rdReq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("pass_pop_valid", 32'(rdValid), 32'h1);
      chk("pass_pop_data", rdData, 32'(i * 4));
    end
    chk("pass_drained", 32'(rdEmpty), 32'h1);
    tick();
    chk("pass_extra_valid", 32'(rdValid), 32'h0);
    chk("pass_extra_hold", rdData, 32'h14);
    rdReq = 1'b0;

    // Overflow: 20 writes into 16 entries, oldest four dropped
    do_reset();
    for (int i = 0; i < 20; i++) begin
      fetch(32'(i * 4), (i == 19) ? 32'h0 : 32'h13);
    end
    chk("fail_status", 32'(status), 32'h2);
    chk("fail_done", 32'(done), 32'h1);
    rdReq = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("wrap_pop_valid", 32'(rdValid), 32'h1);
      chk("wrap_pop_data", rdData, 32'h10 + 32'(i * 4));
    end
    tick();
    chk("wrap_17th_valid", 32'(rdValid), 32'h0);
    chk("wrap_17th_empty", 32'(rdEmpty), 32'h1);
    rdReq = 1'b0;

    // Reset mid-readout acts immediately
    do_reset();
    for (int i = 0; i < 8; i++) begin
      fetch(32'(i * 4), (i == 7) ? 32'h1 : 32'h13);
    end
    rdReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_pop_data", rdData, 32'(i * 4));
    end
    #2;
    sysRes = 1'b1;
    #1;
    chk("abort_status", 32'(status), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_empty", 32'(rdEmpty), 32'h1);
    chk("abort_rdvalid", 32'(rdValid), 32'h0);
    chk("abort_rddata", rdData, 32'h0);
    rdReq = 1'b0;
    #2;
    sysRes = 1'b0;
    tick();
    chk("abort_after_valid", 32'(rdValid), 32'h0);
    chk("abort_after_empty", 32'(rdEmpty), 32'h1);

    // Timeout boundary with TIMEOUT_CYCLES=100: edges 0..98 stay in RUN
    do_reset();
    repeat (99) @(posedge sysClk);
    #1;
    chk("to_before_edge99", 32'(status), 32'h0);
    tick();
`ifdef TRACE_MONITOR_TIMEOUT_EN
    chk("to_after_edge99", 32'(status), 32'h3);
`else
    chk("to_disabled", 32'(status), 32'h0);
`endif

    do_reset();
    repeat (99) @(posedge sysClk);
    #1;
    fetch(32'h100, 32'h1);
    chk("to_pass_wins", 32'(status), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
